// File: rtl/pixel_mixer_pkg.sv
// rtl/pixel_mixer_pkg.sv - shared mode encodings and default parameters for pixel_mixer
package pixel_mixer_pkg;

  localparam int CH_W_DEF    = 8;
  localparam int NUM_CH_DEF  = 3;
  localparam int ALPHA_W_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    MODE_XOR    = 2'd0,
    MODE_AVG    = 2'd1,
    MODE_ADDSAT = 2'd2,
    MODE_BLEND  = 2'd3
  } mix_mode_e;

endpackage

// File: rtl/pixel_mixer_mix_channel.sv
// rtl/pixel_mixer_mix_channel.sv - combinational arithmetic for one colour channel
// The alpha input must already be clamped to 2^ALPHA_W by the caller.
module mix_channel
  import pixel_mixer_pkg::*;
#(
  parameter int CH_W    = CH_W_DEF,
  parameter int ALPHA_W = ALPHA_W_DEF
) (
  input  logic [CH_W-1:0]  c1,
  input  logic [CH_W-1:0]  c2,
  input  logic [1:0]       mode,
  input  logic [ALPHA_W:0] a,
  output logic [CH_W-1:0]  y
);

  localparam int PW = CH_W + ALPHA_W + 1;
  localparam logic [ALPHA_W:0] ALPHA_ONE = {1'b1, {ALPHA_W{1'b0}}};

  logic [CH_W:0]    sum;
  logic [ALPHA_W:0] a_inv;
  logic [PW-1:0]    prod1;
  logic [PW-1:0]    prod2;
  logic [PW-1:0]    blend;

  assign sum   = {1'b0, c1} + {1'b0, c2};
  assign a_inv = ALPHA_ONE - a;
  assign prod1 = PW'(c1) * PW'(a);
  assign prod2 = PW'(c2) * PW'(a_inv);
  assign blend = prod1 + prod2;

  always_comb begin
    y = '0;
    case (mix_mode_e'(mode))
      MODE_XOR:    y = c1 ^ c2;
      MODE_AVG:    y = sum[CH_W:1];
      MODE_ADDSAT: y = sum[CH_W] ? {CH_W{1'b1}} : sum[CH_W-1:0];
      MODE_BLEND:  y = blend[ALPHA_W +: CH_W];
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/pixel_mixer.sv
// rtl/pixel_mixer.sv - two-stage per-channel pixel mixer with valid/ready flow control
// S1 holds operands, S2 holds the result; both stall together on output backpressure.
module pixel_mixer
  import pixel_mixer_pkg::*;
#(
  parameter int CH_W    = CH_W_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ALPHA_W = ALPHA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*CH_W-1:0]   color_in1,
  input  logic [NUM_CH*CH_W-1:0]   color_in2,
  input  logic [1:0]               mode,
  input  logic [ALPHA_W:0]         alpha,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*CH_W-1:0]   color_out,
  output logic [CNT_W-1:0]         pix_cnt
);

  localparam int W = NUM_CH * CH_W;
  localparam logic [ALPHA_W:0] ALPHA_ONE = {1'b1, {ALPHA_W{1'b0}}};

  logic             en;
  logic [ALPHA_W:0] alpha_clamped;
  logic [W-1:0]     mixed;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_c1_q, s1_c1_d;
  logic [W-1:0]     s1_c2_q, s1_c2_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [ALPHA_W:0] s1_alpha_q, s1_alpha_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     color_out_q, color_out_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mix_channel #(
      .CH_W   (CH_W),
      .ALPHA_W(ALPHA_W)
    ) u_mix (
      .c1  (s1_c1_q[g*CH_W +: CH_W]),
      .c2  (s1_c2_q[g*CH_W +: CH_W]),
      .mode(s1_mode_q),
      .a   (s1_alpha_q),
      .y   (mixed[g*CH_W +: CH_W])
    );
  end

  always_comb begin
    en            = !out_valid_q || out_ready;
    alpha_clamped = (alpha > ALPHA_ONE) ? ALPHA_ONE : alpha;

    s1_valid_d  = s1_valid_q;
    s1_c1_d     = s1_c1_q;
    s1_c2_d     = s1_c2_q;
    s1_mode_d   = s1_mode_q;
    s1_alpha_d  = s1_alpha_q;
    out_valid_d = out_valid_q;
    color_out_d = color_out_q;
    pix_cnt_d   = pix_cnt_q;

    // Bubbles travel with the valid bits; data registers load regardless.
    if (en) begin
      s1_valid_d  = in_valid;
      s1_c1_d     = color_in1;
      s1_c2_d     = color_in2;
      s1_mode_d   = mode;
      s1_alpha_d  = alpha_clamped;
      out_valid_d = s1_valid_q;
      color_out_d = mixed;
      if (in_valid) begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_c1_q     <= '0;
      s1_c2_q     <= '0;
      s1_mode_q   <= '0;
      s1_alpha_q  <= '0;
      out_valid_q <= 1'b0;
      color_out_q <= '0;
      pix_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_c1_q     <= s1_c1_d;
      s1_c2_q     <= s1_c2_d;
      s1_mode_q   <= s1_mode_d;
      s1_alpha_q  <= s1_alpha_d;
      out_valid_q <= out_valid_d;
      color_out_q <= color_out_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign color_out = color_out_q;
  assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_pixel_mixer.sv
// tb/tb_pixel_mixer.sv - directed vector bench for pixel_mixer
module tb_pixel_mixer;

  typedef struct {
    logic [23:0] c1;
    logic [23:0] c2;
    logic [1:0]  md;
    logic [8:0]  al;
    logic [23:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] color_in1 = '0;
  logic [23:0] color_in2 = '0;
  logic [1:0]  mode = '0;
  logic [8:0]  alpha = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] color_out;
  logic [3:0]  pix_cnt;

  int checks = 0;
  int failures = 0;

  pixel_mixer #(.CH_W(8), .NUM_CH(3), .ALPHA_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .color_in1(color_in1),
    .color_in2(color_in2),
    .mode     (mode),
    .alpha    (alpha),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .color_out(color_out),
    .pix_cnt  (pix_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] avg24(input logic [23:0] a, input logic [23:0] b);
    logic [8:0] s;
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, a[k*8 +: 8]} + {1'b0, b[k*8 +: 8]};
      r[k*8 +: 8] = s[8:1];
    end
    return r;
  endfunction

  vec_t        vecs[10];
  logic [23:0] bp_c1[10];
  logic [23:0] bp_c2[10];
  logic [23:0] bp_exp[10];

  initial begin
    int sent;
    int recv;
    int cyc;
    logic stalled;
    logic [23:0] held;

    vecs[0] = '{24'hFF00AA, 24'h0F0F0F, 2'd0, 9'd0,   24'hF00FA5};
    vecs[1] = '{24'hF08010, 24'h20A0F0, 2'd2, 9'd0,   24'hFFFFFF};
    vecs[2] = '{24'hF08010, 24'h20A0F0, 2'd1, 9'd0,   24'h889080};
    vecs[3] = '{24'hFF0000, 24'h0000FF, 2'd3, 9'd128, 24'h7F007F};
    vecs[4] = '{24'hFF0000, 24'h0000FF, 2'd3, 9'd256, 24'hFF0000};
    vecs[5] = '{24'hFF0000, 24'h0000FF, 2'd3, 9'd300, 24'hFF0000};
    vecs[6] = '{24'hFF0000, 24'h0000FF, 2'd3, 9'd0,   24'h0000FF};
    vecs[7] = '{24'h01FF80, 24'h010190, 2'd2, 9'd0,   24'h02FFFF};
    vecs[8] = '{24'hFFFFFF, 24'hFFFFFF, 2'd1, 9'd0,   24'hFFFFFF};
    vecs[9] = '{24'h80FF40, 24'h4000C0, 2'd3, 9'd64,  24'h503FA0};

    // reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_color_out", 32'(color_out), 32'd0);
    check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // directed vectors, one at a time, checking 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      color_in1 = vecs[i].c1;
      color_in2 = vecs[i].c2;
      mode      = vecs[i].md;
      alpha     = vecs[i].al;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_color", i), 32'(color_out), 32'(vecs[i].exp));
    end
    check("cnt_after_vectors", 32'(pix_cnt), 32'd10);

    // counter wrap with CNT_W=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 1'b0;
    check("cnt_wrap", 32'(pix_cnt), 32'd1);
    tick();
    tick();
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // stall: counter and S1/S2 contents hold while in_ready is low
    color_in1 = 24'h123456;
    color_in2 = 24'h000000;
    mode      = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    color_in1 = 24'h654321;
    tick();
    color_in1 = 24'hABCDEF;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d_cnt", i), 32'(pix_cnt), 32'd3);
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_color", i), 32'(color_out), 32'h123456);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release_valid", 32'(out_valid), 32'd1);
    check("stall_release_color", 32'(color_out), 32'h654321);
    tick();
    check("stall_release_empty", 32'(out_valid), 32'd0);
    check("stall_release_cnt", 32'(pix_cnt), 32'd3);

    // reset with two pixels in flight
    color_in1 = 24'h111111;
    in_valid  = 1'b1;
    tick();
    color_in1 = 24'h222222;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    color_in1 = 24'h0A0B0C;
    color_in2 = 24'h000000;
    mode      = 2'd0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("postrst_early_valid", 32'(out_valid), 32'd0);
    tick();
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_color", 32'(color_out), 32'h0A0B0C);
    tick();
    check("postrst_no_stale", 32'(out_valid), 32'd0);
    check("postrst_cnt", 32'(pix_cnt), 32'd1);

    // backpressure stream, alternating XOR and AVG per pixel
    for (int i = 0; i < 10; i++) begin
      bp_c1[i]  = 24'h102030 + 24'(i) * 24'h0D0B07;
      bp_c2[i]  = 24'h5A3C1E ^ (24'(i) * 24'h030507);
      bp_exp[i] = i[0] ? avg24(bp_c1[i], bp_c2[i]) : (bp_c1[i] ^ bp_c2[i]);
    end
    sent = 0;
    recv = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (recv < 10 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      if (sent < 10) begin
        color_in1 = bp_c1[sent];
        color_in2 = bp_c2[sent];
        mode      = {1'b0, sent[0]};
        alpha     = 9'd0;
      end
      #1;
      if (stalled) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_color", 32'(color_out), 32'(held));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_result%0d", recv), 32'(color_out), 32'(bp_exp[recv]));
        recv++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = bp_exp[recv];
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_all_received", 32'(recv), 32'd10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_no_duplicate", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
